// File: rtl/contador_param.sv
`default_nettype none
// ============================================================================
//  Module      : contador_param
//  Description : Parameterised multi-mode counter. Supports up/down counting
//                by 1 or by STEP with modulo wrap and ripple-carry pulse,
//                saturating up/down counting with a saturation flag, and a
//                range-checked parallel load. Every output is registered.
//  Revision    : 1.0  initial release
// ============================================================================
module contador_param #(
    parameter int              WIDTH  = 4,
    parameter longint unsigned MODULO = 64'd1 << WIDTH,
    parameter int              STEP   = 3
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
    input  logic [2:0]       modo,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             sat,
    output logic             load_err
);

    // ------------------------------------------------------------------------
    // Operating modes
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_MODE_UP1     = 3'b000;
    localparam logic [2:0] c_MODE_DN1     = 3'b001;
    localparam logic [2:0] c_MODE_DNSTEP  = 3'b010;
    localparam logic [2:0] c_MODE_LOAD    = 3'b011;
    localparam logic [2:0] c_MODE_UPSTEP  = 3'b100;
    localparam logic [2:0] c_MODE_SATUP   = 3'b101;
    localparam logic [2:0] c_MODE_SATDN   = 3'b110;
    localparam logic [2:0] c_MODE_HOLD    = 3'b111;

    // All wrap arithmetic is carried one bit wider than the count so that
    // MODULO = 2**WIDTH and sums up to 2*MODULO-2 are representable.
    localparam logic [WIDTH:0] c_MOD     = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0] c_MOD_M1  = (WIDTH+1)'(MODULO - 64'd1);
    localparam logic [WIDTH:0] c_ONE     = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] c_STEP    = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] c_ZERO    = '0;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] q_q,   q_d;
    logic             rco_q, rco_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;

    // ------------------------------------------------------------------------
    // Wrap helpers. Result MSB is the wrap (ripple-carry) indication, the
    // lower WIDTH bits are the next count value.
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH:0] f_wrap_up(input logic [WIDTH:0] cur,
                                                 input logic [WIDTH:0] k);
        logic [WIDTH:0] sum;
        sum = cur + k;
        if (sum >= c_MOD) begin
            f_wrap_up = {1'b1, WIDTH'(sum - c_MOD)};
        end else begin
            f_wrap_up = {1'b0, WIDTH'(sum)};
        end
    endfunction

    function automatic logic [WIDTH:0] f_wrap_down(input logic [WIDTH:0] cur,
                                                   input logic [WIDTH:0] k);
        if (cur < k) begin
            // cur + (MODULO - k) stays below MODULO, no overflow in WIDTH+1.
            f_wrap_down = {1'b1, WIDTH'(cur + (c_MOD - k))};
        end else begin
            f_wrap_down = {1'b0, WIDTH'(cur - k)};
        end
    endfunction

    // ------------------------------------------------------------------------
    // Combinational arithmetic for every mode
    // ------------------------------------------------------------------------
    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_d_ext;
    logic [WIDTH:0] w_up1;
    logic [WIDTH:0] w_dn1;
    logic [WIDTH:0] w_upstep;
    logic [WIDTH:0] w_dnstep;
    logic           w_q_oor;
    logic           w_d_oor;
    logic           w_counting;
    logic           w_at_top;
    logic           w_at_bottom;

    assign w_q_ext     = {1'b0, q_q};
    assign w_d_ext     = {1'b0, D};
    assign w_up1       = f_wrap_up(w_q_ext, c_ONE);
    assign w_dn1       = f_wrap_down(w_q_ext, c_ONE);
    assign w_upstep    = f_wrap_up(w_q_ext, c_STEP);
    assign w_dnstep    = f_wrap_down(w_q_ext, c_STEP);
    assign w_q_oor     = (w_q_ext >= c_MOD);
    assign w_d_oor     = (w_d_ext >= c_MOD);
    assign w_at_top    = (w_q_ext >= c_MOD_M1);
    assign w_at_bottom = (w_q_ext == c_ZERO);
    assign w_counting  = (modo != c_MODE_LOAD) && (modo != c_MODE_HOLD);

    // Next-state selection: hold with flags cleared unless enabled.
    always_comb begin
        q_d   = q_q;
        rco_d = 1'b0;
        sat_d = 1'b0;
        err_d = 1'b0;
        if (enable) begin
            if (w_counting && w_q_oor) begin
                // Recovery from an illegal count value: restart at zero.
                q_d   = '0;
                rco_d = 1'b1;
            end else begin
                case (modo)
                    c_MODE_UP1: begin
                        q_d   = WIDTH'(w_up1);
                        rco_d = w_up1[WIDTH];
                    end
                    c_MODE_DN1: begin
                        q_d   = WIDTH'(w_dn1);
                        rco_d = w_dn1[WIDTH];
                    end
                    c_MODE_DNSTEP: begin
                        q_d   = WIDTH'(w_dnstep);
                        rco_d = w_dnstep[WIDTH];
                    end
                    c_MODE_LOAD: begin
                        if (w_d_oor) begin
                            q_d   = WIDTH'(c_MOD_M1);
                            err_d = 1'b1;
                        end else begin
                            q_d   = D;
                        end
                    end
                    c_MODE_UPSTEP: begin
                        q_d   = WIDTH'(w_upstep);
                        rco_d = w_upstep[WIDTH];
                    end
                    c_MODE_SATUP: begin
                        // Next value equals the top bound exactly when the
                        // current value is already at or one below it.
                        sat_d = (w_q_ext >= (c_MOD_M1 - c_ONE));
                        if (w_at_top) begin
                            q_d = WIDTH'(c_MOD_M1);
                        end else begin
                            q_d = q_q + WIDTH'(1);
                        end
                    end
                    c_MODE_SATDN: begin
                        sat_d = (w_q_ext <= c_ONE);
                        if (w_at_bottom) begin
                            q_d = '0;
                        end else begin
                            q_d = q_q - WIDTH'(1);
                        end
                    end
                    c_MODE_HOLD: begin
                        q_d = q_q;
                    end
                    default: begin
                        q_d = q_q;
                    end
                endcase
            end
        end
    end

    // State update with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            q_q   <= '0;
            rco_q <= 1'b0;
            sat_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            rco_q <= rco_d;
            sat_q <= sat_d;
            err_q <= err_d;
        end
    end

    assign Q        = q_q;
    assign rco      = rco_q;
    assign sat      = sat_q;
    assign load_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_contador_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contador_param
//  Description : Self-checking bench for contador_param (WIDTH=4, MODULO=10,
//                STEP=3). Directed scenarios followed by randomized traffic,
//                compared against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_contador_param;

    localparam int W = 4;
    localparam int M = 10;
    localparam int S = 3;

    logic         clk;
    logic         reset_L;
    logic         enable;
    logic [2:0]   modo;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         rco;
    logic         sat;
    logic         load_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_q   = 0;
    int m_rco = 0;
    int m_sat = 0;
    int m_err = 0;

    contador_param #(
        .WIDTH  (W),
        .MODULO (64'd10),
        .STEP   (S)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .enable   (enable),
        .modo     (modo),
        .D        (D),
        .Q        (Q),
        .rco      (rco),
        .sat      (sat),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Q"},        int'(Q),        m_q);
        check({tag, ".rco"},      int'(rco),      m_rco);
        check({tag, ".sat"},      int'(sat),      m_sat);
        check({tag, ".load_err"}, int'(load_err), m_err);
    endtask

    // Behaviour of one rising edge, written directly from the mode rules.
    task automatic model_step(input bit en, input int mode, input int d);
        int q;
        q     = m_q;
        m_rco = 0;
        m_sat = 0;
        m_err = 0;
        if (en) begin
            case (mode)
                0: begin m_rco = (q + 1 >= M); q = (q + 1) % M; end
                1: begin m_rco = (q < 1);      q = (q - 1 + M) % M; end
                2: begin m_rco = (q < S);      q = (q - S + M) % M; end
                3: begin
                    if (d >= M) begin q = M - 1; m_err = 1; end
                    else        q = d;
                end
                4: begin m_rco = (q + S >= M); q = (q + S) % M; end
                5: begin q = (q + 1 > M - 1) ? M - 1 : q + 1; m_sat = (q == M - 1); end
                6: begin q = (q - 1 < 0) ? 0 : q - 1;         m_sat = (q == 0); end
                default: ;
            endcase
        end
        m_q = q;
    endtask

    // One clock edge with the given inputs, then compare against the model.
    task automatic tick(input bit en, input int mode, input int d, input string tag);
        @(negedge clk);
        enable = en;
        modo   = 3'(mode);
        D      = W'(d);
        model_step(en, mode, d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset pulse between edges; outputs must clear before the next edge.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        enable = 1'b0;
        #2;
        reset_L = 1'b0;
        m_q = 0; m_rco = 0; m_sat = 0; m_err = 0;
        #1;
        check_all(tag);
        #1;
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L = 1'b0;
        enable  = 1'b0;
        modo    = 3'b000;
        D       = '0;
        #12;
        check_all("por");
        @(negedge clk);
        reset_L = 1'b1;

        // Up count by one through a full wrap.
        for (int i = 0; i < 10; i++) tick(1'b1, 0, 0, "up1");
        check("up_wrap_q",   int'(Q),   0);
        check("up_wrap_rco", int'(rco), 1);

        // Step-down wrap.
        tick(1'b1, 3, 1, "ld1");
        tick(1'b1, 2, 0, "dnstep_a");
        check("dnstep_wrap_q",   int'(Q),   8);
        check("dnstep_wrap_rco", int'(rco), 1);
        tick(1'b1, 2, 0, "dnstep_b");
        check("dnstep_q5", int'(Q), 5);

        // Load range check.
        tick(1'b1, 3, 12, "ld_oor");
        check("ld_oor_q",   int'(Q),        9);
        check("ld_oor_err", int'(load_err), 1);
        tick(1'b1, 3, 6, "ld_ok");
        check("ld_ok_err", int'(load_err), 0);

        // Saturation up and down.
        tick(1'b1, 3, 8, "ld8");
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 5, 0, "satup");
            check("satup_q",   int'(Q),   9);
            check("satup_sat", int'(sat), 1);
        end
        tick(1'b1, 3, 1, "ld1b");
        tick(1'b1, 6, 0, "satdn");
        check("satdn_q",   int'(Q),   0);
        check("satdn_sat", int'(sat), 1);
        tick(1'b1, 6, 0, "satdn_hold");

        // Enable gating and asynchronous reset.
        tick(1'b1, 3, 4, "ld4");
        tick(1'b0, 4, 0, "en_off");
        check("en_off_q", int'(Q), 4);
        tick(1'b1, 4, 0, "en_on");
        check("en_on_q", int'(Q), 7);
        reset_pulse("mid_reset");
        tick(1'b1, 4, 0, "post_reset");
        check("post_reset_q", int'(Q), 3);

        // Explicit hold mode and back-to-back mode changes.
        tick(1'b1, 7, 0, "hold");
        tick(1'b1, 1, 0, "dn1");
        tick(1'b1, 1, 0, "dn1b");
        tick(1'b1, 1, 0, "dn1c");
        tick(1'b1, 1, 0, "dn1_wrap");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset_pulse("rnd_reset");
            end else begin
                tick($urandom_range(0, 7) != 0,
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 15)),
                     "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter WIDTH, default 4, meaning counter width in bits (legal range 2..32).
REQ-002 Parameter MODULO, default 2**WIDTH, meaning count range 0..MODULO-1 (legal range 2..2**WIDTH).
REQ-003 Parameter STEP, default 3, meaning increment/decrement size for step modes (legal range 1..MODULO-1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_L  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  count qualifier; low = hold.
REQ-007 modo  input  3  operating mode select.
REQ-008 D  input  WIDTH  parallel load value.
REQ-009 Q  output  WIDTH  registered count value.
REQ-010 rco  output  1  registered ripple-carry pulse on wrap.
REQ-011 sat  output  1  registered saturation flag.
REQ-012 load_err  output  1  registered out-of-range load flag.

Function
REQ-013 All outputs SHALL be registered; each edge with enable=1 SHALL compute the next Q, rco, sat and load_err from current Q, modo and D, with 1-cycle latency.
REQ-014 With enable=0, Q SHALL hold and rco, sat and load_err SHALL be 0 on the next edge.
REQ-015 modo 000 SHALL count up by 1 modulo MODULO.
REQ-016 modo 001 SHALL count down by 1 modulo MODULO.
REQ-017 modo 010 SHALL count down by STEP modulo MODULO.
REQ-018 modo 011 SHALL load D.
REQ-019 modo 100 SHALL count up by STEP modulo MODULO.
REQ-020 modo 101 SHALL count up by 1, saturating at MODULO-1.
REQ-021 modo 110 SHALL count down by 1, saturating at 0.
REQ-022 modo 111 SHALL hold Q with all flags 0.
REQ-023 Up-wrap: if Q+k >= MODULO, next Q SHALL be Q+k-MODULO, and rco SHALL be 1 for exactly the cycle in which the wrapped value is presented.
REQ-024 Down-wrap: if Q < k, next Q SHALL be Q+MODULO-k, and rco SHALL be 1 for that one cycle.
REQ-025 Non-wrapping updates SHALL drive rco=0.
REQ-026 Wrap arithmetic SHALL use WIDTH+1-bit intermediates, so that no overflow can occur when MODULO=2**WIDTH.
REQ-027 In saturating modes, sat SHALL be 1 whenever next Q equals the saturation bound (including when holding at it), and rco SHALL always be 0.
REQ-028 Load with D < MODULO SHALL set Q=D, load_err=0 and rco=0.
REQ-029 Load with D >= MODULO SHALL set Q=MODULO-1 and load_err=1 for one cycle.
REQ-030 A mode change SHALL take effect on the first edge at which it is sampled, with no dead cycle.
REQ-031 If Q holds a value >= MODULO, which is unreachable in operation, the next enabled edge in any counting mode SHALL force Q=0 and rco=1.

Reset
REQ-032 reset_L=0 SHALL immediately (asynchronously) force Q=0, rco=0, sat=0 and load_err=0, regardless of clk.
REQ-033 Reset asserted mid-count SHALL abandon any pending update.
REQ-034 After release, the first enabled rising edge SHALL act on Q=0.
REQ-035 Reset release SHALL be synchronised externally, so this block requires no internal release logic.

Verification (WIDTH=4, MODULO=10, STEP=3)
REQ-036 Reset: assert reset_L=0 between clock edges -> Q=0, rco=0, sat=0, load_err=0 before the next edge.
REQ-037 Up wrap: modo=000, enable=1, 10 edges from Q=0 -> Q sequence 1..9 then 0; rco=1 only while Q=0 after 9.
REQ-038 Step down wrap: load 1, then modo=010 -> Q=8, rco=1 for one cycle; next edge -> Q=5, rco=0.
REQ-039 Load range: modo=011, D=12 -> Q=9, load_err=1 one cycle; then D=6 -> Q=6, load_err=0.
REQ-040 Saturate: load 8, modo=101 for 3 edges -> Q=9,9,9; sat=1 from the first 9; rco=0 throughout. Then modo=110 from Q=1 -> Q=0, sat=1.
REQ-041 Enable and reset: at Q=4, modo=100 with enable=0 -> Q holds at 4; enable=1 -> Q=7; then reset_L pulsed low mid-cycle -> Q=0 immediately, and the next enabled edge -> Q=3.
